// File: rtl/jt51_so_pkg.sv
// jt51_so_pkg
// Shared frame geometry for the YM2151-style serial output deserializer.
// Frame is 16 bits, LSB first: 3 don't-care bits, 10-bit mantissa, 3-bit exponent.
// Optional build macro used by the channel module: JT51_SO_ERRCHK_EN.
package jt51_so_pkg;

    localparam int FRAME_LEN  = 16;
    localparam int DUMMY_BITS = 3;
    localparam int MAN_W      = 10;
    localparam int EXP_W      = 3;
    localparam int MAN_LSB    = DUMMY_BITS;
    localparam int EXP_LSB    = DUMMY_BITS + MAN_W;

    // Bit counter must be able to tell 16 from longer frames; saturates at 31.
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } so_word_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/jt51_so_chan.sv
// jt51_so_chan
// One channel of the serial output deserializer. Shifts so in while sh is high
// (sampled on cen), and on the falling edge of sh latches the mantissa/exponent
// slices and pulses valid for one clk.
// Build option: JT51_SO_ERRCHK_EN -- frames whose bit count is not 16 do not
// update the outputs and pulse err instead; without it err is constant 0.
// Ports:
//   rst    async active-high reset
//   clk    system clock
//   cen    serial bit-clock enable
//   so     serial data, LSB first
//   sh     frame strobe for this channel
//   man    10-bit two's-complement mantissa (registered)
//   exp    3-bit exponent (registered)
//   valid  one-clk pulse when man/exp update
//   err    one-clk pulse on a wrong-length frame
module jt51_so_chan
    import jt51_so_pkg::*;
(
    input  logic             rst,
    input  logic             clk,
    input  logic             cen,
    input  logic             so,
    input  logic             sh,
    output logic [MAN_W-1:0] man,
    output logic [EXP_W-1:0] exp,
    output logic             valid,
    output logic             err
);

    logic [FRAME_LEN-1:0] sr;
    logic [CNT_W-1:0]     cnt;
    logic                 sh_prev;
    logic                 close;
    so_word_t             word;

    // Edges are only seen across consecutive cen samples.
    assign close = cen & ~sh & sh_prev;

    // Slices of the current shift register; for frames longer than 16 bits the
    // register simply holds the most recent 16.
    assign word.man = sr[MAN_LSB +: MAN_W];
    assign word.exp = sr[EXP_LSB +: EXP_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            sh_prev <= 1'b0;
        end else if (cen) begin
            sh_prev <= sh;
            if (sh) begin
                sr  <= {so, sr[FRAME_LEN-1:1]};
                // First sample of a frame counts as bit 1.
                cnt <= sh_prev ? sat_inc(cnt) : CNT_W'(1);
            end
        end
    end

    // Pulses are cleared every clk so they stay one clk wide whatever cen does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            man   <= '0;
            exp   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (close) begin
`ifdef JT51_SO_ERRCHK_EN
                if (cnt == CNT_W'(FRAME_LEN)) begin
                    man   <= word.man;
                    exp   <= word.exp;
                    valid <= 1'b1;
                end else begin
                    err   <= 1'b1;
                end
`else
                man   <= word.man;
                exp   <= word.exp;
                valid <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/jt51_so_deser.sv
// jt51_so_deser
// YM2151-style serial audio output deserializer. Left channel frames on sh1,
// right channel on sh2; both share so and cen and are fully independent, so
// their frames may overlap.
// Build option: JT51_SO_ERRCHK_EN enables frame-length checking (frame_err).
// Ports:
//   rst, clk                  async active-high reset, system clock
//   cen                       serial bit-clock enable
//   so, sh1, sh2              serial data and left/right frame strobes
//   left_man/left_exp/left_valid     left decoded word and update pulse
//   right_man/right_exp/right_valid  right decoded word and update pulse
//   frame_err                 one-clk pulse on a wrong-length frame, either channel
module jt51_so_deser
    import jt51_so_pkg::*;
(
    input  logic             rst,
    input  logic             clk,
    input  logic             cen,
    input  logic             so,
    input  logic             sh1,
    input  logic             sh2,
    output logic [MAN_W-1:0] left_man,
    output logic [EXP_W-1:0] left_exp,
    output logic             left_valid,
    output logic [MAN_W-1:0] right_man,
    output logic [EXP_W-1:0] right_exp,
    output logic             right_valid,
    output logic             frame_err
);

    logic left_err;
    logic right_err;

    jt51_so_chan u_left (
        .rst   (rst),
        .clk   (clk),
        .cen   (cen),
        .so    (so),
        .sh    (sh1),
        .man   (left_man),
        .exp   (left_exp),
        .valid (left_valid),
        .err   (left_err)
    );

    jt51_so_chan u_right (
        .rst   (rst),
        .clk   (clk),
        .cen   (cen),
        .so    (so),
        .sh    (sh2),
        .man   (right_man),
        .exp   (right_exp),
        .valid (right_valid),
        .err   (right_err)
    );

    assign frame_err = left_err | right_err;

endmodule
